uart_tx_buffered: RTL

//  8N1 UART transmitter with a small byte FIFO in front of it. Frame: 1 start bit (0),
//  8 data bits LSB first, 1 stop bit (1); line idles high. Pairs with the UART receiver
//  (same CLKS_PER_BIT) as the outbound half of the serial link on the FPGA.
//  The FIFO lets upstream logic queue bytes; queued frames go out back-to-back with no gap.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_buffered.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, frame levels and default bit timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS            = 8;
  localparam logic        START_LEVEL          = 1'b0;
  localparam logic        STOP_LEVEL           = 1'b1;
  localparam logic        IDLE_LEVEL           = 1'b1;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count; pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == (PW+1)'(DEPTH));
    empty_o = (count_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    data_o  = mem_q[rd_q];
    count_o = count_q;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small byte FIFO; queued frames are sent back-to-back.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic [7:0]                    TX_Data,
  input  logic                          TX_Valid,
  output logic                          TX_Ready,
  output logic                          TX_Serial,
  output logic                          TX_Active,
  output logic                          TX_Done,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 2");
  end

  tx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   serial_q, serial_d;

  logic                   bit_last;
  logic                   pop;
  logic [DATA_BITS-1:0]   fifo_data;
  logic                   fifo_full, fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Reset_n),
    .push_i  (TX_Valid),
    .data_i  (TX_Data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .count_o (FIFO_Count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign TX_Ready  = !fifo_full;
  assign TX_Serial = serial_q;
  assign bit_last  = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
    end
  end

  // The line level is computed one cycle ahead so TX_Serial comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_last ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        serial_d = IDLE_LEVEL;
        if (pop) begin
          shift_d  = fifo_data;
          idx_d    = '0;
          state_d  = START;
          serial_d = START_LEVEL;
        end
      end
      START: begin
        if (bit_last) begin
          state_d  = DATA;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
        end
      end
      DATA: begin
        if (bit_last) begin
          if (idx_q == IW'(DATA_BITS - 1)) begin
            state_d  = STOP;
            serial_d = STOP_LEVEL;
          end else begin
            idx_d    = idx_q + IW'(1);
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end
      STOP: begin
        if (bit_last) begin
          if (pop) begin
            shift_d  = fifo_data;
            idx_d    = '0;
            state_d  = START;
            serial_d = START_LEVEL;
          end else begin
            state_d  = IDLE;
            serial_d = IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = IDLE_LEVEL;
      end
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    TX_Done   = 1'b0;
    TX_Active = (state_q != IDLE);
    case (state_q)
      IDLE: pop = !fifo_empty;
      STOP: begin
        if (bit_last) begin
          TX_Done = 1'b1;
          pop     = !fifo_empty;
        end
      end
      default: ;
    endcase
  end

endmodule
